// File: rtl/wow_sample_pkg.sv
// rtl/wow_sample_pkg.sv - shared types and constants for the WoW sample DDRAM reader
//
// Purpose: FSM state encoding, line/lane/DDRAM address widths, default base
// address and the line-to-DDRAM-word address helper.
package wow_sample_pkg;

  localparam int LINE_W = 21;  // 64-bit line index, s_addr[23:3]
  localparam int LANE_W = 2;   // 16-bit lane within a line, s_addr[2:1]
  localparam int DDR_AW = 29;  // DDRAM 64-bit word address width

  localparam logic [DDR_AW-1:0] DEF_BASE_ADDR = 29'h0600000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_PF_ISSUE,
    ST_PF_WAIT
  } state_e;

  // DDRAM word address of a sample line; wraps naturally at 2^29.
  function automatic logic [DDR_AW-1:0] line_addr(input logic [DDR_AW-1:0] base,
                                                  input logic [LINE_W-1:0] line);
    return base + {{(DDR_AW-LINE_W){1'b0}}, line};
  endfunction

endpackage

// File: rtl/wow_sample_line_buf.sv
// rtl/wow_sample_line_buf.sv - one cached 64-bit sample line with tag, valid, lane mux and hit compare
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   clr_i                 invalidate the line (wins over a write)
//   wr_en_i, wr_data_i,   load a new line and its tag, marking it valid
//   wr_tag_i
//   lookup_tag_i, hit_o   hit when valid and the stored tag equals lookup_tag_i
//   lane_i, lane_data_o   16-bit word selected from the stored line
//   data_o, tag_o         raw line contents, used to promote a line between buffers
module wow_sample_line_buf
  import wow_sample_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [63:0]       wr_data_i,
  input  logic [LINE_W-1:0] wr_tag_i,
  input  logic [LINE_W-1:0] lookup_tag_i,
  input  logic [LANE_W-1:0] lane_i,
  output logic              hit_o,
  output logic [15:0]       lane_data_o,
  output logic [63:0]       data_o,
  output logic [LINE_W-1:0] tag_o
);

  logic [63:0]       data_q;
  logic [LINE_W-1:0] tag_q;
  logic              valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (wr_en_i) begin
      data_q  <= wr_data_i;
      tag_q   <= wr_tag_i;
      valid_q <= 1'b1;
    end
  end

  assign hit_o  = valid_q && (tag_q == lookup_tag_i);
  assign data_o = data_q;
  assign tag_o  = tag_q;

  always_comb begin
    lane_data_o = data_q[15:0];
    case (lane_i)
      2'd0: lane_data_o = data_q[15:0];
      2'd1: lane_data_o = data_q[31:16];
      2'd2: lane_data_o = data_q[47:32];
      2'd3: lane_data_o = data_q[63:48];
      default: lane_data_o = data_q[15:0];
    endcase
  end

endmodule

// File: rtl/wow_sample_ddram_reader.sv
// rtl/wow_sample_ddram_reader.sv - 16-bit sample read responder backed by the DDRAM 64-bit burst port
//
// Optional feature macro: WOW_SAMPLE_PREFETCH_EN (background prefetch of line+1
// into a second line buffer). Default build has a single line buffer.
//
// Ports:
//   CLK, I_RESET            clock, asynchronous active-high reset
//   s_enable                samples playable; low flushes the cache and blocks requests
//   s_addr, s_read          sample byte address (bit 0 ignored) and one-cycle read strobe
//   s_data, s_ready         returned sample word and its one-cycle valid pulse
//   s_busy                  request in progress; s_read ignored while high
//   DDRAM_BUSY              arbiter stall
//   DDRAM_ADDR, DDRAM_RD,   read command (held stable while DDRAM_BUSY)
//   DDRAM_BURSTCNT
//   DDRAM_DOUT,             read data and its valid strobe
//   DDRAM_DOUT_READY
module wow_sample_ddram_reader
  import wow_sample_pkg::*;
#(
  parameter logic [DDR_AW-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [7:0]        BURST     = 8'd1
) (
  input  logic              CLK,
  input  logic              I_RESET,
  input  logic              s_enable,
  input  logic [23:0]       s_addr,
  input  logic              s_read,
  output logic [15:0]       s_data,
  output logic              s_ready,
  output logic              s_busy,
  input  logic              DDRAM_BUSY,
  output logic [DDR_AW-1:0] DDRAM_ADDR,
  output logic [7:0]        DDRAM_BURSTCNT,
  output logic              DDRAM_RD,
  input  logic [63:0]       DDRAM_DOUT,
  input  logic              DDRAM_DOUT_READY
);

  state_e            state_q;
  logic [LINE_W-1:0] line_q;
  logic [LANE_W-1:0] lane_q;
  logic [15:0]       s_data_q;
  logic              s_ready_q, s_busy_q, rd_q, flush_pend_q;
  logic [DDR_AW-1:0] addr_q;

  logic [LINE_W-1:0] req_line, look_line, main_tag, main_wr_tag;
  logic [LANE_W-1:0] req_lane;
  logic [63:0]       main_data, main_wr_data;
  logic [15:0]       main_word;
  logic              main_hit, main_hit_eff, resolved_hit, main_wr, buf_clr, take_req;
  logic              unused_addr_bit, unused_main;

  assign req_line        = s_addr[23:3];
  assign req_lane        = s_addr[2:1];
  assign unused_addr_bit = s_addr[0];
  assign unused_main     = ^{main_data, main_tag};

  // Invalidate when idle with s_enable low, or once an in-flight transaction
  // that saw s_enable drop has delivered its response.
  assign buf_clr = ((state_q == ST_IDLE) || (state_q == ST_RESP)) && (!s_enable || flush_pend_q);
  // A flush still pending means the cached line is stale even if valid.
  assign main_hit_eff = main_hit && !flush_pend_q;

`ifdef WOW_SAMPLE_PREFETCH_EN
  logic              pend_q, pf_want_q, filled_q, pf_hit, promote, pf_wr, unused_pf;
  logic [LINE_W-1:0] pf_line_q, pf_tag;
  logic [63:0]       pf_data;
  logic [15:0]       pf_word;

  // pend_q holds a request captured while a prefetch owned the DDRAM port.
  assign take_req     = (s_read && s_enable) || pend_q;
  assign look_line    = pend_q ? line_q : req_line;
  assign promote      = (state_q == ST_IDLE) && take_req && !main_hit_eff && pf_hit && !flush_pend_q;
  assign resolved_hit = main_hit_eff || promote;
  assign main_wr      = ((state_q == ST_WAIT) && DDRAM_DOUT_READY) || promote;
  assign main_wr_data = promote ? pf_data : DDRAM_DOUT;
  assign main_wr_tag  = promote ? pf_tag : line_q;
  assign pf_wr        = (state_q == ST_PF_WAIT) && DDRAM_DOUT_READY;
  assign unused_pf    = ^pf_word;

  wow_sample_line_buf u_pf_buf (
    .clk_i(CLK), .rst_i(I_RESET), .clr_i(buf_clr || promote),
    .wr_en_i(pf_wr), .wr_data_i(DDRAM_DOUT), .wr_tag_i(pf_line_q),
    .lookup_tag_i(look_line), .lane_i(lane_q), .hit_o(pf_hit),
    .lane_data_o(pf_word), .data_o(pf_data), .tag_o(pf_tag)
  );
`else
  assign take_req     = s_read && s_enable;
  assign look_line    = req_line;
  assign resolved_hit = main_hit_eff;
  assign main_wr      = (state_q == ST_WAIT) && DDRAM_DOUT_READY;
  assign main_wr_data = DDRAM_DOUT;
  assign main_wr_tag  = line_q;
`endif

  wow_sample_line_buf u_main_buf (
    .clk_i(CLK), .rst_i(I_RESET), .clr_i(buf_clr),
    .wr_en_i(main_wr), .wr_data_i(main_wr_data), .wr_tag_i(main_wr_tag),
    .lookup_tag_i(look_line), .lane_i(lane_q), .hit_o(main_hit),
    .lane_data_o(main_word), .data_o(main_data), .tag_o(main_tag)
  );

  always_ff @(posedge CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q      <= ST_IDLE;
      line_q       <= '0;
      lane_q       <= '0;
      s_data_q     <= '0;
      s_ready_q    <= 1'b0;
      s_busy_q     <= 1'b0;
      rd_q         <= 1'b0;
      addr_q       <= '0;
      flush_pend_q <= 1'b0;
`ifdef WOW_SAMPLE_PREFETCH_EN
      pend_q       <= 1'b0;
      pf_want_q    <= 1'b0;
      filled_q     <= 1'b0;
      pf_line_q    <= '0;
`endif
    end else begin
      s_ready_q <= 1'b0;
      if (buf_clr)
        flush_pend_q <= 1'b0;
      else if (!s_enable && (state_q != ST_IDLE))
        flush_pend_q <= 1'b1;

`ifdef WOW_SAMPLE_PREFETCH_EN
      if (((state_q == ST_PF_ISSUE) || (state_q == ST_PF_WAIT)) && s_read && s_enable && !pend_q) begin
        line_q   <= req_line;
        lane_q   <= req_lane;
        s_busy_q <= 1'b1;
        pend_q   <= 1'b1;
      end
`endif

      case (state_q)
        ST_IDLE: begin
          if (take_req) begin
`ifdef WOW_SAMPLE_PREFETCH_EN
            if (!pend_q) begin
              line_q <= req_line;
              lane_q <= req_lane;
            end
            pend_q   <= 1'b0;
            filled_q <= !main_hit_eff;
`else
            line_q <= req_line;
            lane_q <= req_lane;
`endif
            s_busy_q <= 1'b1;
            if (resolved_hit) begin
              state_q <= ST_RESP;
            end else begin
              rd_q    <= 1'b1;
              addr_q  <= line_addr(BASE_ADDR, look_line);
              state_q <= ST_ISSUE;
            end
          end
`ifdef WOW_SAMPLE_PREFETCH_EN
          else if (pf_want_q && s_enable && !flush_pend_q) begin
            pf_want_q <= 1'b0;
            pf_line_q <= line_q + 1'b1;
            rd_q      <= 1'b1;
            addr_q    <= line_addr(BASE_ADDR, line_q + 1'b1);
            state_q   <= ST_PF_ISSUE;
          end
`endif
        end
        ST_ISSUE: begin
          if (!DDRAM_BUSY) begin
            rd_q    <= 1'b0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (DDRAM_DOUT_READY) state_q <= ST_RESP;
        end
        ST_RESP: begin
          s_data_q  <= main_word;
          s_ready_q <= 1'b1;
          s_busy_q  <= 1'b0;
          state_q   <= ST_IDLE;
`ifdef WOW_SAMPLE_PREFETCH_EN
          // The last line has no successor; the tag never wraps.
          if (filled_q && s_enable && !flush_pend_q && (line_q != '1)) pf_want_q <= 1'b1;
`endif
        end
`ifdef WOW_SAMPLE_PREFETCH_EN
        ST_PF_ISSUE: begin
          if (!DDRAM_BUSY) begin
            rd_q    <= 1'b0;
            state_q <= ST_PF_WAIT;
          end
        end
        ST_PF_WAIT: begin
          if (DDRAM_DOUT_READY) state_q <= ST_IDLE;
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_data         = s_data_q;
  assign s_ready        = s_ready_q;
  assign s_busy         = s_busy_q;
  assign DDRAM_ADDR     = addr_q;
  assign DDRAM_RD       = rd_q;
  assign DDRAM_BURSTCNT = BURST;

endmodule
